// File: rtl/ofifo.sv
// ofifo: row-aligned output FIFO behind the MAC array south edge.
//   One independent FIFO per column, each written by that column's valid
//   strobe. A single rd pops every column together, so the row always
//   comes out aligned regardless of the skew on the write side.
// Ports:
//   clk, reset      clock, async active-low reset
//   in  [pbw*col]   column psums, column c at [pbw*(c+1)-1 : pbw*c]
//   wr  [col]       per-column write strobe
//   rd              pop one entry from every column (only while o_valid)
//   o_ready/o_full  no column full / some column full
//   o_valid         every column holds at least one entry
//   out, out_valid  registered popped row, one-cycle valid pulse
//   overflow        sticky: a write was dropped on a full column

// Single-column FIFO. Pointers carry one extra bit so full and empty
// stay distinct after wrap-around.
module ofifo_col #(
  parameter int PSUM_BW = 16,
  parameter int DEPTH   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PSUM_BW-1:0] wdata_i,
  input  logic               wr_i,
  input  logic               pop_i,
  output logic [PSUM_BW-1:0] rdata_o,
  output logic               empty_o,
  output logic               full_o,
  output logic               drop_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

  logic [AW:0]        wptr_q, wptr_d, rptr_q, rptr_d, count;
  logic [PSUM_BW-1:0] mem_q [DEPTH];
  logic               write_ok;

  assign count   = wptr_q - rptr_q;
  assign empty_o = (count == '0);
  assign full_o  = (count == FULL_CNT);
  // A pop on the same edge frees a slot, so a full column still accepts.
  assign write_ok = wr_i & (~full_o | pop_i);
  assign drop_o   = wr_i & full_o & ~pop_i;
  assign rdata_o  = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (write_ok) wptr_d = wptr_q + 1'b1;
    if (pop_i)    rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage is never reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (write_ok) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end
endmodule

module ofifo #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [psum_bw*col-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic                   o_ready,
  output logic                   o_full,
  output logic                   o_valid,
  output logic [psum_bw*col-1:0] out,
  output logic                   out_valid,
  output logic                   overflow
);
  logic [col-1:0][psum_bw-1:0] in_row, rd_row, out_q, out_d;
  logic [col-1:0]              empty, full, drop;
  logic                        pop, out_valid_q, overflow_q, overflow_d;

  assign in_row  = in;
  assign o_valid = ~|empty;
  assign o_full  = |full;
  assign o_ready = ~o_full;
  assign pop     = rd & o_valid;

  for (genvar c = 0; c < col; c++) begin : g_col
    ofifo_col #(.PSUM_BW(psum_bw), .DEPTH(depth)) u_col (
      .clk     (clk),
      .reset   (reset),
      .wdata_i (in_row[c]),
      .wr_i    (wr[c]),
      .pop_i   (pop),
      .rdata_o (rd_row[c]),
      .empty_o (empty[c]),
      .full_o  (full[c]),
      .drop_o  (drop[c])
    );
  end

  always_comb begin
    out_d      = out_q;
    overflow_d = overflow_q | (|drop);
    if (pop) out_d = rd_row;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= pop;
      overflow_q  <= overflow_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign overflow  = overflow_q;
endmodule

// File: tb/tb_ofifo.sv
module tb_ofifo;
  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] in_d;
  logic [7:0]   wr;
  logic         rd;
  logic         o_ready, o_full, o_valid, out_valid, overflow;
  logic [127:0] out_w;

  int checks = 0;
  int errors = 0;

  // Reference model: one queue of psums per column.
  logic [15:0]  mq [8][$];
  logic [127:0] exp_out;
  logic         exp_ov, exp_ovf;

  ofifo dut (
    .clk(clk), .reset(reset), .in(in_d), .wr(wr), .rd(rd),
    .o_ready(o_ready), .o_full(o_full), .o_valid(o_valid),
    .out(out_w), .out_valid(out_valid), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic m_valid();
    for (int c = 0; c < 8; c++) if (mq[c].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic m_full();
    for (int c = 0; c < 8; c++) if (mq[c].size() == 16) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [4:0] m_status();
    return {m_valid(), m_full(), ~m_full(), exp_ov, exp_ovf};
  endfunction

  function automatic logic [127:0] rand_row();
    logic [127:0] d;
    for (int c = 0; c < 8; c++) d[c*16 +: 16] = 16'($urandom);
    return d;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 8; c++) mq[c].delete();
    exp_out = '0; exp_ov = 1'b0; exp_ovf = 1'b0;
  endtask

  // Drive one cycle at the falling edge, advance the model, then land 1
  // time unit after the rising edge so outputs can be sampled.
  task automatic step(input logic [7:0] w, input logic [127:0] d, input logic r);
    logic p;
    logic f [8];
    @(negedge clk);
    wr = w; in_d = d; rd = r;
    p = r && m_valid();
    for (int c = 0; c < 8; c++) f[c] = (mq[c].size() == 16);
    if (p) for (int c = 0; c < 8; c++) exp_out[c*16 +: 16] = mq[c].pop_front();
    for (int c = 0; c < 8; c++)
      if (w[c]) begin
        if (!f[c] || p) mq[c].push_back(d[c*16 +: 16]);
        else exp_ovf = 1'b1;
      end
    exp_ov = p;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    wr = '0; rd = 1'b0; reset = 1'b0;
    model_clear();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; wr = 8'hFF; rd = 1'b1; in_d = rand_row();
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({o_valid, o_full, o_ready, out_valid, overflow} !== 5'b00100 || out_w !== '0) begin
      errors++;
      $display("FAIL reset_hold status=%b out=%h exp status=00100 out=0",
               {o_valid, o_full, o_ready, out_valid, overflow}, out_w);
    end
    @(negedge clk);
    reset = 1'b1; wr = '0; rd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(8'h00, '0, 1'b0);
      checks++;
      if ({o_valid, o_full, o_ready, out_valid, overflow} !== 5'b00100 || out_w !== '0) begin
        errors++;
        $display("FAIL reset_idle%0d status=%b out=%h exp status=00100 out=0",
                 i, {o_valid, o_full, o_ready, out_valid, overflow}, out_w);
      end
    end
  endtask

  task automatic test_skew();
    logic [127:0] d, row;
    for (int c = 0; c < 8; c++) begin
      d = rand_row();
      d[c*16 +: 16] = 16'h0100 + 16'(c);
      row[c*16 +: 16] = 16'h0100 + 16'(c);
      step(8'(1 << c), d, 1'b0);
      checks++;
      if (o_valid !== (c == 7)) begin
        errors++;
        $display("FAIL skew_valid col%0d got=%b exp=%b", c, o_valid, (c == 7));
      end
    end
    step(8'h00, '0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_w !== row || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL skew_read ov=%b out=%h valid=%b exp ov=1 out=%h valid=0",
               out_valid, out_w, o_valid, row);
    end
    step(8'h00, '0, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || out_w !== row) begin
      errors++;
      $display("FAIL skew_hold ov=%b out=%h exp ov=0 out=%h", out_valid, out_w, row);
    end
  endtask

  task automatic test_full_overflow();
    for (int i = 0; i < 16; i++) step(8'hFF, rand_row(), 1'b0);
    checks++;
    if ({o_full, o_ready, overflow} !== 3'b100) begin
      errors++;
      $display("FAIL full_flags got=%b exp=100", {o_full, o_ready, overflow});
    end
    step(8'hFF, rand_row(), 1'b0);
    checks++;
    if (overflow !== 1'b1 || o_full !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set ovf=%b full=%b exp 1 1", overflow, o_full);
    end
    for (int i = 0; i < 16; i++) begin
      step(8'h00, '0, 1'b1);
      checks++;
      if (out_w !== exp_out || out_valid !== 1'b1 || overflow !== 1'b1) begin
        errors++;
        $display("FAIL drain%0d out=%h ov=%b ovf=%b exp out=%h ov=1 ovf=1",
                 i, out_w, out_valid, overflow, exp_out);
      end
    end
    checks++;
    if (o_valid !== 1'b0 || o_full !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty valid=%b full=%b exp 0 0", o_valid, o_full);
    end
  endtask

  task automatic test_full_pop();
    logic [127:0] last;
    do_reset();
    for (int i = 0; i < 16; i++) step(8'hFF, rand_row(), 1'b0);
    last = rand_row();
    step(8'hFF, last, 1'b1);
    checks++;
    if ({o_valid, o_full, o_ready, out_valid, overflow} !== m_status() || out_w !== exp_out
        || o_full !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_pop status=%b out=%h exp status=%b out=%h",
               {o_valid, o_full, o_ready, out_valid, overflow}, out_w, m_status(), exp_out);
    end
    for (int i = 0; i < 16; i++) begin
      step(8'h00, '0, 1'b1);
      checks++;
      if (out_w !== exp_out || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL full_pop_drain%0d out=%h ov=%b exp out=%h ov=1",
                 i, out_w, out_valid, exp_out);
      end
    end
    checks++;
    if (out_w !== last || o_valid !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_pop_last out=%h valid=%b ovf=%b exp out=%h valid=0 ovf=0",
               out_w, o_valid, overflow, last);
    end
  endtask

  task automatic test_wrap();
    int wrote = 0, got = 0, cyc = 0;
    logic [7:0] w;
    logic r;
    while (got < 40 && cyc < 600) begin
      w = (wrote < 40 && mq[0].size() < 16 && $urandom_range(0, 2) != 0) ? 8'hFF : 8'h00;
      r = 1'($urandom_range(0, 1));
      if (w != 0) wrote++;
      step(w, rand_row(), r);
      if (exp_ov) got++;
      checks++;
      if ({o_valid, o_full, o_ready, out_valid, overflow} !== m_status()) begin
        errors++;
        $display("FAIL wrap_status cyc%0d got=%b exp=%b",
                 cyc, {o_valid, o_full, o_ready, out_valid, overflow}, m_status());
      end
      if (exp_ov) begin
        checks++;
        if (out_w !== exp_out) begin
          errors++;
          $display("FAIL wrap_data row%0d got=%h exp=%h", got, out_w, exp_out);
        end
      end
      cyc++;
    end
    checks++;
    if (got != 40) begin
      errors++;
      $display("FAIL wrap_timeout rows=%0d exp=40", got);
    end
  endtask

  task automatic test_mid_reset();
    logic [127:0] row;
    do_reset();
    for (int i = 0; i < 5; i++) step(8'hFF, rand_row(), 1'b0);
    checks++;
    if (o_valid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre valid=%b exp=1", o_valid);
    end
    #1;
    wr = '0; rd = 1'b0; reset = 1'b0;
    #1;
    checks++;
    if ({o_valid, o_full, o_ready, out_valid, overflow} !== 5'b00100) begin
      errors++;
      $display("FAIL midrst_async status=%b exp=00100",
               {o_valid, o_full, o_ready, out_valid, overflow});
    end
    model_clear();
    #1 reset = 1'b1;
    row = rand_row();
    step(8'hFF, row, 1'b0);
    step(8'hFF, rand_row(), 1'b0);
    step(8'h00, '0, 1'b1);
    checks++;
    if (out_w !== row || out_valid !== 1'b1 || exp_out !== row) begin
      errors++;
      $display("FAIL midrst_first out=%h ov=%b exp out=%h ov=1", out_w, out_valid, row);
    end
  endtask

  initial begin
    test_reset();
    test_skew();
    test_full_overflow();
    test_full_pop();
    test_wrap();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ofifo.md
Name: ofifo

Overview:
Output FIFO that sits directly downstream of the 8x8 MAC array and captures its south-edge partial sums.
- Columns of the array emit results on different cycles because instructions are skewed row by row. This block therefore keeps one independent FIFO per column, written by that column's valid bit.
- Reads are row-aligned: one rd pops one entry from every column at once, producing a full psum_bw*col word for the SFU / psum memory.

Parameters:
col, 8, number of columns; equals the MAC array column count
psum_bw, 16, width of one partial sum in bits
depth, 16, entries per column FIFO; power of two, >= 2

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
in  input  psum_bw*col  psum from MAC array out_s; column c occupies bits [psum_bw*(c+1)-1 : psum_bw*c]
wr  input  col  per-column write strobe; connected to MAC array valid
rd  input  1  read request; pops one entry from all columns
o_ready  output  1  high when no column FIFO is full
o_full  output  1  high when any column FIFO is full
o_valid  output  1  high when every column FIFO holds at least one entry
out  output  psum_bw*col  registered row of popped psums, same column packing as in
out_valid  output  1  one-cycle pulse, high the cycle out is updated
overflow  output  1  sticky error flag; a write was dropped on a full column

Behaviour:
- Reset (reset=0, asynchronous):
  - All write/read pointers cleared to 0.
  - out=0, out_valid=0, overflow=0.
  - o_valid=0, o_full=0, o_ready=1.
  - Memory contents need not be cleared.
  - Reset asserted mid-operation discards all stored entries immediately.
- Storage: per column, a depth-entry array with wptr[c] and rptr[c], each log2(depth)+1 bits. The extra MSB distinguishes full from empty on wrap-around.
  - count[c] = wptr[c] - rptr[c], modulo 2^(log2(depth)+1).
  - Column empty when count[c] == 0; full when count[c] == depth.
- Status outputs (combinational from pointers):
  - o_valid = AND over c of (count[c] != 0).
  - o_full = OR over c of (count[c] == depth).
  - o_ready = ~o_full.
- Read acceptance: pop = rd & o_valid.
  - When pop: every rptr[c] increments by 1, and out <= entries at the current rptr of each column, all captured on the same edge.
  - out_valid <= pop, so latency is one cycle from the rd edge to out/out_valid.
  - out holds its last value while out_valid=0.
  - rd while o_valid=0 is ignored: no pointer change, out_valid=0.
- Write acceptance, per column independently: write_ok[c] = wr[c] & ((count[c] != depth) | pop).
  - When write_ok[c]: mem[c][wptr[c]] <= in slice c, and wptr[c] increments.
  - Full column with simultaneous pop: the write is accepted and the count stays at depth.
  - wr[c] on a full column without pop: data dropped, pointer unchanged, overflow <= 1. Overflow stays high until reset.
- Empty-column bypass: a write to an empty column is not readable in the same cycle. o_valid reflects the write at the earliest on the following cycle. There is no bypass path.
- Simultaneous write and pop on the same column: both take effect; count[c] unchanged.
- Pointer wrap: pointers roll over modulo 2^(log2(depth)+1) with no glitch on o_full or o_valid at the depth boundary.
- Columns may fill to different levels; only the least-filled column limits o_valid.

Test Plan:
- Reset: hold reset=0 with wr=8'hFF and rd=1 -> o_valid=0, o_ready=1, out=0, out_valid=0, overflow=0. Release and idle 3 cycles -> no change.
- Skewed fill:
  - Drive wr one-hot shifting 8'h01 -> 8'h80 on consecutive cycles, with column c data = 16'h0100+c.
  - Expect o_valid low until the cycle after the column-7 write, then high.
  - rd=1 -> next cycle out_valid=1 and out = {16'h0107,...,16'h0100}; o_valid returns to 0.
- Full and overflow:
  - Write depth=16 rows with wr=8'hFF -> o_full=1, o_ready=0.
  - A 17th write with rd=0 -> overflow=1 and the stored data is unchanged.
  - Drain 16 rows -> values returned in write order 0..15; afterwards o_valid=0.
- Write on full with simultaneous pop: while full, assert wr=8'hFF and rd=1 together -> count stays 16, overflow stays 0. The new row is returned last after 16 further reads.
- Wrap-around: run 40 rows through with a random read/write interleave that never exceeds depth -> output order exactly matches input order, with no spurious o_full or o_valid transitions at pointer rollover.
- Reset mid-operation: with 5 rows stored, pulse reset=0 asynchronously between clock edges -> o_valid=0 immediately. After release, the first new row written is the first row read.
